// File: rtl/qpsk_frame_gen_pkg.sv
// Shared types, LFSR taps and symbol-mapping helpers for the QPSK frame generator.
package qpsk_frame_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        PAYLOAD,
        GAP
    } state_t;

    localparam int          PRBS_TAP_OUT      = 8;
    localparam int          PRBS_TAP_FB       = 4;
    localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hEB90_146F;

    // One Fibonacci step of x^9+x^5+1; the output bit is s[8] before the shift.
    function automatic logic [8:0] prbs_step1(input logic [8:0] s);
        return {s[7:0], s[PRBS_TAP_OUT] ^ s[PRBS_TAP_FB]};
    endfunction

    function automatic logic [1:0] prbs_dibit_of(input logic [8:0] s);
        logic [8:0] s1;
        s1 = prbs_step1(s);
        return {s[PRBS_TAP_OUT], s1[PRBS_TAP_OUT]};
    endfunction

    function automatic logic [1:0] gray_map(input logic [1:0] d);
        return {d[1], d[1] ^ d[0]};
    endfunction

endpackage

// File: rtl/qpsk_frame_gen_if.sv
// Symbol stream between the frame generator (master) and the modulator (slave).
interface qpsk_frame_gen_if;
    logic       en;
    logic [1:0] base_data;
    logic       sym_valid;
    logic       frame_start;
    logic       in_payload;

    modport master (input en, output base_data, sym_valid, frame_start, in_payload);
    modport slave  (output en, input base_data, sym_valid, frame_start, in_payload);
endinterface

// File: rtl/qpsk_frame_gen_prbs9_dibit.sv
// PRBS-9 source producing two bits per step; also used by the demod-side checker.
module prbs9_dibit
    import qpsk_frame_gen_pkg::*;
#(
    parameter logic [8:0] SEED = 9'h1FF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    output logic [1:0] dibit
);
    logic [8:0] s_q;
    logic [8:0] base;

    // With load and step together the seed's dibit is consumed in the same edge.
    assign base  = load ? SEED : s_q;
    assign dibit = prbs_dibit_of(s_q);

    always_ff @(posedge clk) begin
        if (rst)
            s_q <= SEED;
        else if (step)
            s_q <= prbs_step1(prbs_step1(base));
        else if (load)
            s_q <= SEED;
    end
endmodule

// File: rtl/qpsk_frame_gen.sv
// Framed QPSK symbol source: preamble, sync word, PRBS-9 payload, idle gap.
// Build option QPSK_GRAY_MAP_EN Gray-codes every dibit before it is registered.
module qpsk_frame_gen
    import qpsk_frame_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 1200,
    parameter int unsigned PREAMBLE_LEN = 16,
    parameter logic [31:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
    parameter int unsigned PAYLOAD_LEN  = 256,
    parameter int unsigned GAP_LEN      = 8,
    parameter logic [8:0]  PRBS_SEED    = 9'h1FF
) (
    input  logic                clk,
    input  logic                rst,
    qpsk_frame_gen_if.master    bus
);
    state_t      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] div_q;
    logic        tick;
    logic [1:0]  dibit_d, sym_mapped, prbs_dibit;
    logic        fs_d, pay_d, prbs_load, prbs_step;
    logic [31:0] sync_sh;
    logic [1:0]  base_q;
    logic        sv_q, fs_q, pay_q;

    assign tick = (div_q == 16'(CLK_DIV - 1));

    prbs9_dibit #(.SEED(PRBS_SEED)) u_prbs (
        .clk   (clk),
        .rst   (rst),
        .load  (prbs_load & tick),
        .step  (prbs_step & tick),
        .dibit (prbs_dibit)
    );

    // Next-symbol decode: describes what gets presented at the coming tick.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q + 16'd1;
        dibit_d   = 2'b00;
        fs_d      = 1'b0;
        pay_d     = 1'b0;
        prbs_load = 1'b0;
        prbs_step = 1'b0;
        sync_sh   = SYNC_WORD << {idx_q[3:0] + 4'd1, 1'b0};
        case (state_q)
            IDLE: begin
                state_d = PREAMBLE;
                idx_d   = '0;
                fs_d    = 1'b1;
            end
            PREAMBLE: begin
                if (idx_q == 16'(PREAMBLE_LEN - 1)) begin
                    state_d = SYNC;
                    idx_d   = '0;
                    dibit_d = SYNC_WORD[31:30];
                end else begin
                    dibit_d = {2{~idx_q[0]}};
                end
            end
            SYNC: begin
                if (idx_q == 16'd15) begin
                    state_d   = PAYLOAD;
                    idx_d     = '0;
                    prbs_load = 1'b1;
                    prbs_step = 1'b1;
                    dibit_d   = prbs_dibit_of(PRBS_SEED);
                    pay_d     = 1'b1;
                end else begin
                    dibit_d = sync_sh[31:30];
                end
            end
            PAYLOAD: begin
                if (idx_q == 16'(PAYLOAD_LEN - 1)) begin
                    idx_d = '0;
                    if (GAP_LEN == 0) begin
                        state_d = PREAMBLE;
                        fs_d    = 1'b1;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    prbs_step = 1'b1;
                    dibit_d   = prbs_dibit;
                    pay_d     = 1'b1;
                end
            end
            GAP: begin
                if (idx_q == 16'(GAP_LEN - 1)) begin
                    state_d = PREAMBLE;
                    idx_d   = '0;
                    fs_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

`ifdef QPSK_GRAY_MAP_EN
    assign sym_mapped = gray_map(dibit_d);
`else
    assign sym_mapped = dibit_d;
`endif

    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            state_q <= IDLE;
            idx_q   <= '0;
            div_q   <= '0;
            base_q  <= 2'b00;
            sv_q    <= 1'b0;
            fs_q    <= 1'b0;
            pay_q   <= 1'b0;
        end else begin
            sv_q <= tick;
            fs_q <= 1'b0;
            if (tick) begin
                div_q   <= '0;
                state_q <= state_d;
                idx_q   <= idx_d;
                base_q  <= sym_mapped;
                fs_q    <= fs_d;
                pay_q   <= pay_d;
            end else begin
                div_q <= div_q + 16'd1;
            end
        end
    end

    assign bus.base_data   = base_q;
    assign bus.sym_valid   = sv_q;
    assign bus.frame_start = fs_q;
    assign bus.in_payload  = pay_q;
endmodule

// File: tb/tb_qpsk_frame_gen.sv
// Self-checking bench for qpsk_frame_gen against a symbol-list model of one frame.
module tb_qpsk_frame_gen;
    localparam int          CLK_DIV = 4;
    localparam int          PRE     = 4;
    localparam int          PAY     = 8;
    localparam int          GAPL    = 2;
    localparam int          FLEN    = PRE + 16 + PAY + GAPL;
    localparam logic [31:0] SW      = 32'hEB90_146F;
    localparam logic [8:0]  SEED    = 9'h1FF;

    logic clk = 1'b0;
    logic rst;
    qpsk_frame_gen_if bus();

    qpsk_frame_gen #(
        .CLK_DIV(CLK_DIV), .PREAMBLE_LEN(PRE), .SYNC_WORD(SW),
        .PAYLOAD_LEN(PAY), .GAP_LEN(GAPL), .PRBS_SEED(SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         pos   = 0;
    int         fs_cyc = 0;
    logic [1:0] exp_sym [FLEN];
    logic       exp_pay [FLEN];

    function automatic logic [1:0] map_sym(input logic [1:0] d);
`ifdef QPSK_GRAY_MAP_EN
        return {d[1], d[1] ^ d[0]};
`else
        return d;
`endif
    endfunction

    // Frame content straight from the frame rules: bit-serial LFSR, MSB-first sync.
    task automatic build_model();
        logic [8:0]  s;
        logic [31:0] w;
        logic        b1, b0;
        w = SW;
        for (int i = 0; i < FLEN; i++) begin exp_sym[i] = 2'b00; exp_pay[i] = 1'b0; end
        for (int i = 0; i < PRE; i++) exp_sym[i] = (i % 2 == 1) ? 2'b11 : 2'b00;
        for (int k = 0; k < 16; k++) exp_sym[PRE + k] = {w[31 - 2*k], w[30 - 2*k]};
        s = SEED;
        for (int j = 0; j < PAY; j++) begin
            b1 = s[8]; s = {s[7:0], s[8] ^ s[4]};
            b0 = s[8]; s = {s[7:0], s[8] ^ s[4]};
            exp_sym[PRE + 16 + j] = {b1, b0};
            exp_pay[PRE + 16 + j] = 1'b1;
        end
        for (int i = 0; i < FLEN; i++) exp_sym[i] = map_sym(exp_sym[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Checks every clock for nsym symbols, starting right after a sym_valid at pos.
    task automatic run_syms(input int nsym, output int pay_cnt);
        int since, got, guard;
        since = 0; got = 0; guard = 0; pay_cnt = 0;
        while (got < nsym && guard < nsym * CLK_DIV + 50) begin
            tick(); guard++; since++;
            if (bus.sym_valid === 1'b1) begin
                pos = (pos + 1) % FLEN;
                tests++;
                if (since !== CLK_DIV || bus.base_data !== exp_sym[pos] ||
                    bus.in_payload !== exp_pay[pos] || bus.frame_start !== (pos == 0)) begin
                    fails++;
                    $display("FAIL symbol pos=%0d spacing=%0d data=%b pay=%b fs=%b, want spacing=%0d data=%b pay=%b fs=%b",
                             pos, since, bus.base_data, bus.in_payload, bus.frame_start,
                             CLK_DIV, exp_sym[pos], exp_pay[pos], pos == 0);
                end
                if (bus.in_payload === 1'b1) pay_cnt++;
                if (bus.frame_start === 1'b1) begin
                    tests++;
                    if (cyc - fs_cyc !== FLEN * CLK_DIV) begin
                        fails++;
                        $display("FAIL frame_spacing got %0d clocks want %0d", cyc - fs_cyc, FLEN * CLK_DIV);
                    end
                    fs_cyc = cyc;
                end
                since = 0; got++;
            end else begin
                tests++;
                if (bus.frame_start !== 1'b0 || bus.base_data !== exp_sym[pos] ||
                    bus.in_payload !== exp_pay[pos]) begin
                    fails++;
                    $display("FAIL hold pos=%0d data=%b fs=%b pay=%b, want data=%b fs=0 pay=%b",
                             pos, bus.base_data, bus.frame_start, bus.in_payload, exp_sym[pos], exp_pay[pos]);
                end
            end
        end
        tests++;
        if (got < nsym) begin
            fails++;
            $display("FAIL symbol_timeout got %0d symbols want %0d", got, nsym);
        end
    endtask

    task automatic advance_to(input int target);
        int n, dummy;
        n = (target - pos + FLEN) % FLEN;
        if (n == 0) n = FLEN;
        run_syms(n, dummy);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.en = 1'b0;
        repeat (3) tick();
        tests++;
        if ({bus.base_data, bus.sym_valid, bus.frame_start, bus.in_payload} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs got %b want 00000",
                     {bus.base_data, bus.sym_valid, bus.frame_start, bus.in_payload});
        end
        rst = 1'b0;
        tick();
        tests++;
        if (bus.sym_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_pulse got sym_valid=%b want 0", bus.sym_valid);
        end
    endtask

    // en (already high) has just been raised or rst just released; first symbol is due.
    task automatic test_first_symbol(input string tag);
        int n;
        n = 0;
        do begin tick(); n++; end while (bus.sym_valid !== 1'b1 && n < 20);
        tests++;
        if (n !== CLK_DIV || bus.frame_start !== 1'b1 || bus.base_data !== exp_sym[0] ||
            bus.in_payload !== 1'b0) begin
            fails++;
            $display("FAIL %s_first_symbol edges=%0d fs=%b data=%b pay=%b, want edges=%0d fs=1 data=%b pay=0",
                     tag, n, bus.frame_start, bus.base_data, bus.in_payload, CLK_DIV, exp_sym[0]);
        end
        pos = 0;
        fs_cyc = cyc;
    endtask

    task automatic test_frames();
        int pc;
        run_syms(2 * FLEN, pc);
        tests++;
        if (pc !== 2 * PAY) begin
            fails++;
            $display("FAIL payload_count got %0d want %0d", pc, 2 * PAY);
        end
    endtask

    task automatic test_en_drop();
        int pc;
        advance_to(PRE + $urandom_range(0, 15));
        repeat ($urandom_range(0, CLK_DIV - 1)) tick();
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if ({bus.base_data, bus.sym_valid, bus.frame_start, bus.in_payload} !== 5'b0) begin
                fails++;
                $display("FAIL en_low_outputs clk=%0d got %b want 00000", i,
                         {bus.base_data, bus.sym_valid, bus.frame_start, bus.in_payload});
            end
        end
        bus.en = 1'b1;
        test_first_symbol("reenable");
        run_syms(FLEN, pc);
    endtask

    task automatic test_rst_mid();
        int pc;
        advance_to(PRE + 16 + $urandom_range(0, PAY - 1));
        repeat ($urandom_range(0, CLK_DIV - 1)) tick();
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) begin
            tick();
            tests++;
            if ({bus.base_data, bus.sym_valid, bus.frame_start, bus.in_payload} !== 5'b0) begin
                fails++;
                $display("FAIL rst_mid_outputs got %b want 00000",
                         {bus.base_data, bus.sym_valid, bus.frame_start, bus.in_payload});
            end
        end
        rst = 1'b0;
        test_first_symbol("after_rst");
        run_syms(FLEN, pc);
        tests++;
        if (pc !== PAY) begin
            fails++;
            $display("FAIL rst_payload_count got %0d want %0d", pc, PAY);
        end
    endtask

    initial begin
        build_model();
        test_reset();
        bus.en = 1'b1;
        test_first_symbol("enable");
        test_frames();
        test_en_drop();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end
endmodule
